id_ex_stage: RTL and testbench

Decode-to-execute pipeline stage that sits directly downstream of the register file read ports. It drives the two read addresses, captures the operands together with the decoded control bundle into the ID/EX pipeline register, and bypasses a same-cycle writeback. The register file writes on the clock edge and has no internal bypass, so this stage performs the WB→ID bypass. It also detects load-use hazards, inserts one-cycle bubbles, and honours downstream stall and branch flush.

---
 rtl/riscv_pkg.sv | 37 +++
 rtl/id_ex_stage_if.sv | 61 ++++++
 rtl/load_use_detect.sv | 29 ++
 rtl/id_ex_stage.sv | 95 +++++++++
 tb/tb_id_ex_stage.sv | 294 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/riscv_pkg.sv
// riscv_pkg: shared widths, control-bundle layout and the ID/EX register record.
package riscv_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;
  localparam int CTRL_W = 16;

  // Control-bundle field offsets (bundle is passed through this stage untouched)
  localparam int CTRL_ALU_OP_LSB = 0;
  localparam int CTRL_ALU_OP_W   = 4;
  localparam int CTRL_SRC_B_IMM  = 4;
  localparam int CTRL_MEM_WR     = 5;
  localparam int CTRL_BRANCH     = 6;
  localparam int CTRL_JUMP       = 7;
  localparam int CTRL_WB_SEL_LSB = 8;
  localparam int CTRL_WB_SEL_W   = 2;

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [REG_AW-1:0] rd;
    logic              is_load;
    logic              we;
    logic [CTRL_W-1:0] ctrl;
    logic [XLEN-1:0]   imm;
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   rs1_val;
    logic [XLEN-1:0]   rs2_val;
  } id_ex_reg_t;

  // Increment that sticks at all-ones instead of wrapping
  function automatic logic [XLEN-1:0] sat_inc(input logic [XLEN-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// id_ex_stage_if: all non-clock signals of the ID/EX stage; master = the stage, slave = its surroundings.
interface id_ex_stage_if;
  import riscv_pkg::*;

  logic              id_valid;
  logic [REG_AW-1:0] id_rs1;
  logic [REG_AW-1:0] id_rs2;
  logic [REG_AW-1:0] id_rd;
  logic              id_uses_rs1;
  logic              id_uses_rs2;
  logic              id_is_load;
  logic              id_we;
  logic [CTRL_W-1:0] id_ctrl;
  logic [XLEN-1:0]   id_imm;
  logic [XLEN-1:0]   id_pc;

  logic [REG_AW-1:0] rf_a1;
  logic [REG_AW-1:0] rf_a2;
  logic [XLEN-1:0]   rf_rd1;
  logic [XLEN-1:0]   rf_rd2;

  logic              wb_we;
  logic [REG_AW-1:0] wb_rd;
  logic [XLEN-1:0]   wb_wd;

  logic              ex_stall;
  logic              flush;
  logic              id_stall;

  logic              ex_valid;
  logic [REG_AW-1:0] ex_rs1;
  logic [REG_AW-1:0] ex_rs2;
  logic [REG_AW-1:0] ex_rd;
  logic              ex_is_load;
  logic              ex_we;
  logic [CTRL_W-1:0] ex_ctrl;
  logic [XLEN-1:0]   ex_imm;
  logic [XLEN-1:0]   ex_pc;
  logic [XLEN-1:0]   ex_rs1_val;
  logic [XLEN-1:0]   ex_rs2_val;
  logic [XLEN-1:0]   bubble_cnt;

  modport master (
    input  id_valid, id_rs1, id_rs2, id_rd, id_uses_rs1, id_uses_rs2,
           id_is_load, id_we, id_ctrl, id_imm, id_pc,
           rf_rd1, rf_rd2, wb_we, wb_rd, wb_wd, ex_stall, flush,
    output rf_a1, rf_a2, id_stall,
           ex_valid, ex_rs1, ex_rs2, ex_rd, ex_is_load, ex_we, ex_ctrl,
           ex_imm, ex_pc, ex_rs1_val, ex_rs2_val, bubble_cnt
  );

  modport slave (
    output id_valid, id_rs1, id_rs2, id_rd, id_uses_rs1, id_uses_rs2,
           id_is_load, id_we, id_ctrl, id_imm, id_pc,
           rf_rd1, rf_rd2, wb_we, wb_rd, wb_wd, ex_stall, flush,
    input  rf_a1, rf_a2, id_stall,
           ex_valid, ex_rs1, ex_rs2, ex_rd, ex_is_load, ex_we, ex_ctrl,
           ex_imm, ex_pc, ex_rs1_val, ex_rs2_val, bubble_cnt
  );

endinterface

// File: rtl/load_use_detect.sv
// load_use_detect: flags an ID instruction that reads the destination of a load still sitting in EX.
module load_use_detect
  import riscv_pkg::*;
(
  input  logic              id_valid_i,
  input  logic [REG_AW-1:0] id_rs1_i,
  input  logic [REG_AW-1:0] id_rs2_i,
  input  logic              id_uses_rs1_i,
  input  logic              id_uses_rs2_i,
  input  logic              ex_valid_i,
  input  logic              ex_is_load_i,
  input  logic              ex_we_i,
  input  logic [REG_AW-1:0] ex_rd_i,
  output logic              lu_o
);

  logic producer_live;
  logic rs1_hit;
  logic rs2_hit;

  // A load whose result cannot be forwarded in time collides with either used source
  always_comb begin
    producer_live = ex_valid_i && ex_is_load_i && ex_we_i && (ex_rd_i != '0);
    rs1_hit       = id_uses_rs1_i && (id_rs1_i == ex_rd_i);
    rs2_hit       = id_uses_rs2_i && (id_rs2_i == ex_rd_i);
    lu_o          = id_valid_i && producer_live && (rs1_hit || rs2_hit);
  end

endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: RF read, WB->ID bypass, load-use bubble insertion and the ID/EX pipeline register.
module id_ex_stage
  import riscv_pkg::*;
(
  input logic           clk,
  input logic           rst_n,
  id_ex_stage_if.master bus
);

  id_ex_reg_t      ex_q;
  id_ex_reg_t      ex_d;
  logic [XLEN-1:0] bubble_cnt_q;
  logic [XLEN-1:0] bubble_cnt_d;
  logic [XLEN-1:0] op1;
  logic [XLEN-1:0] op2;
  logic            lu;

  assign bus.rf_a1 = bus.id_rs1;
  assign bus.rf_a2 = bus.id_rs2;

  load_use_detect u_load_use_detect (
    .id_valid_i    (bus.id_valid),
    .id_rs1_i      (bus.id_rs1),
    .id_rs2_i      (bus.id_rs2),
    .id_uses_rs1_i (bus.id_uses_rs1),
    .id_uses_rs2_i (bus.id_uses_rs2),
    .ex_valid_i    (ex_q.valid),
    .ex_is_load_i  (ex_q.is_load),
    .ex_we_i       (ex_q.we),
    .ex_rd_i       (ex_q.rd),
    .lu_o          (lu)
  );

  // The RF writes on the same edge we read, so a same-cycle writeback must be forwarded here
  always_comb begin
    op1 = bus.rf_rd1;
    op2 = bus.rf_rd2;
    if (bus.wb_we && (bus.wb_rd != '0) && (bus.wb_rd == bus.id_rs1)) op1 = bus.wb_wd;
    if (bus.wb_we && (bus.wb_rd != '0) && (bus.wb_rd == bus.id_rs2)) op2 = bus.wb_wd;
  end

  // Next ID/EX contents: flush beats stall, stall beats bubble, bubble beats capture
  always_comb begin
    ex_d         = ex_q;
    bubble_cnt_d = bubble_cnt_q;
    if (bus.flush) begin
      ex_d.valid = 1'b0;
    end else if (!bus.ex_stall) begin
      if (lu) begin
        ex_d.valid   = 1'b0;
        ex_d.we      = 1'b0;
        ex_d.is_load = 1'b0;
        bubble_cnt_d = sat_inc(bubble_cnt_q);
      end else begin
        ex_d.valid   = bus.id_valid;
        ex_d.rs1     = bus.id_rs1;
        ex_d.rs2     = bus.id_rs2;
        ex_d.rd      = bus.id_rd;
        ex_d.is_load = bus.id_is_load;
        ex_d.we      = bus.id_we;
        ex_d.ctrl    = bus.id_ctrl;
        ex_d.imm     = bus.id_imm;
        ex_d.pc      = bus.id_pc;
        ex_d.rs1_val = op1;
        ex_d.rs2_val = op2;
      end
    end
  end

  // Pipeline register and bubble counter, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q         <= '0;
      bubble_cnt_q <= '0;
    end else begin
      ex_q         <= ex_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign bus.id_stall   = !bus.flush && (bus.ex_stall || lu);
  assign bus.ex_valid   = ex_q.valid;
  assign bus.ex_rs1     = ex_q.rs1;
  assign bus.ex_rs2     = ex_q.rs2;
  assign bus.ex_rd      = ex_q.rd;
  assign bus.ex_is_load = ex_q.is_load;
  assign bus.ex_we      = ex_q.we;
  assign bus.ex_ctrl    = ex_q.ctrl;
  assign bus.ex_imm     = ex_q.imm;
  assign bus.ex_pc      = ex_q.pc;
  assign bus.ex_rs1_val = ex_q.rs1_val;
  assign bus.ex_rs2_val = ex_q.rs2_val;
  assign bus.bubble_cnt = bubble_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed scenarios plus randomized traffic against a behavioural pipeline model.
`timescale 1ns/1ps
module tb_id_ex_stage;
  import riscv_pkg::*;

  logic clk = 1'b0;
  logic rst_n;

  // 10 ns pipeline clock
  always #5 clk = ~clk;

  id_ex_stage_if bus();

  id_ex_stage dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Architectural register file seen by the stage; written on the edge, no internal bypass
  logic [XLEN-1:0] rfMem [32];
  assign bus.rf_rd1 = (bus.rf_a1 == '0) ? '0 : rfMem[bus.rf_a1];
  assign bus.rf_rd2 = (bus.rf_a2 == '0) ? '0 : rfMem[bus.rf_a2];

  int checkCount = 0;
  int failCount  = 0;

  // Model of what the EX stage currently holds
  logic              mValid, mIsLoad, mWe, mWeKnown;
  logic [REG_AW-1:0] mRs1, mRs2, mRd;
  logic [CTRL_W-1:0] mCtrl;
  logic [XLEN-1:0]   mImm, mPc, mV1, mV2, mCnt;

  // Single comparison point for every check in the bench
  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Latest architectural value of register r as this edge sees it
  function automatic logic [XLEN-1:0] latestValue(input logic [REG_AW-1:0] r);
    if (r == '0) return '0;
    if (bus.wb_we && bus.wb_rd == r) return bus.wb_wd;
    return rfMem[r];
  endfunction

  // Does the instruction in ID need a result that a load in EX has not produced yet
  function automatic logic modelHazard();
    logic needs;
    needs = (bus.id_uses_rs1 && bus.id_rs1 == mRd) || (bus.id_uses_rs2 && bus.id_rs2 == mRd);
    return bus.id_valid && mValid && mIsLoad && mWe && (mRd != '0) && needs;
  endfunction

  function automatic logic expectedStall();
    return !bus.flush && (bus.ex_stall || modelHazard());
  endfunction

  task automatic modelReset();
    mValid = 0; mIsLoad = 0; mWe = 0; mWeKnown = 1;
    mRs1 = '0; mRs2 = '0; mRd = '0; mCtrl = '0;
    mImm = '0; mPc = '0; mV1 = '0; mV2 = '0; mCnt = '0;
  endtask

  task automatic modelEdge();
    if (bus.flush) begin
      mValid = 0;
      mWeKnown = 0;
    end else if (bus.ex_stall) begin
      mValid = mValid;
    end else if (modelHazard()) begin
      mValid = 0; mWe = 0; mIsLoad = 0; mWeKnown = 1;
      if (mCnt != 32'hFFFF_FFFF) mCnt = mCnt + 32'd1;
    end else begin
      mValid = bus.id_valid; mRs1 = bus.id_rs1; mRs2 = bus.id_rs2; mRd = bus.id_rd;
      mIsLoad = bus.id_is_load; mWe = bus.id_we; mWeKnown = 1;
      mCtrl = bus.id_ctrl; mImm = bus.id_imm; mPc = bus.id_pc;
      mV1 = latestValue(bus.id_rs1);
      mV2 = latestValue(bus.id_rs2);
    end
  endtask

  task automatic checkRegs();
    checkOutput("ex_valid", 64'(bus.ex_valid), 64'(mValid));
    checkOutput("bubble_cnt", 64'(bus.bubble_cnt), 64'(mCnt));
    if (mWeKnown) begin
      checkOutput("ex_we", 64'(bus.ex_we), 64'(mWe));
      checkOutput("ex_is_load", 64'(bus.ex_is_load), 64'(mIsLoad));
    end
    if (mValid) begin
      checkOutput("ex_rs1", 64'(bus.ex_rs1), 64'(mRs1));
      checkOutput("ex_rs2", 64'(bus.ex_rs2), 64'(mRs2));
      checkOutput("ex_rd", 64'(bus.ex_rd), 64'(mRd));
      checkOutput("ex_ctrl", 64'(bus.ex_ctrl), 64'(mCtrl));
      checkOutput("ex_imm", 64'(bus.ex_imm), 64'(mImm));
      checkOutput("ex_pc", 64'(bus.ex_pc), 64'(mPc));
      checkOutput("ex_rs1_val", 64'(bus.ex_rs1_val), 64'(mV1));
      checkOutput("ex_rs2_val", 64'(bus.ex_rs2_val), 64'(mV2));
    end
  endtask

  task automatic checkResetState();
    checkOutput("rst_ex_valid", 64'(bus.ex_valid), 64'd0);
    checkOutput("rst_ex_rs1", 64'(bus.ex_rs1), 64'd0);
    checkOutput("rst_ex_rs2", 64'(bus.ex_rs2), 64'd0);
    checkOutput("rst_ex_rd", 64'(bus.ex_rd), 64'd0);
    checkOutput("rst_ex_is_load", 64'(bus.ex_is_load), 64'd0);
    checkOutput("rst_ex_we", 64'(bus.ex_we), 64'd0);
    checkOutput("rst_ex_ctrl", 64'(bus.ex_ctrl), 64'd0);
    checkOutput("rst_ex_imm", 64'(bus.ex_imm), 64'd0);
    checkOutput("rst_ex_pc", 64'(bus.ex_pc), 64'd0);
    checkOutput("rst_ex_rs1_val", 64'(bus.ex_rs1_val), 64'd0);
    checkOutput("rst_ex_rs2_val", 64'(bus.ex_rs2_val), 64'd0);
    checkOutput("rst_bubble_cnt", 64'(bus.bubble_cnt), 64'd0);
  endtask

  task automatic clearInputs();
    bus.id_valid = 0; bus.id_rs1 = '0; bus.id_rs2 = '0; bus.id_rd = '0;
    bus.id_uses_rs1 = 0; bus.id_uses_rs2 = 0; bus.id_is_load = 0; bus.id_we = 0;
    bus.id_ctrl = '0; bus.id_imm = '0; bus.id_pc = '0;
    bus.wb_we = 0; bus.wb_rd = '0; bus.wb_wd = '0;
    bus.ex_stall = 0; bus.flush = 0;
  endtask

  // Random traffic over a small register window so hazards and bypasses occur often
  task automatic applyStimulus();
    bus.id_valid    = ($urandom_range(0, 3) != 0);
    bus.id_rs1      = 5'($urandom_range(0, 7));
    bus.id_rs2      = 5'($urandom_range(0, 7));
    bus.id_rd       = 5'($urandom_range(0, 7));
    bus.id_uses_rs1 = 1'($urandom);
    bus.id_uses_rs2 = 1'($urandom);
    bus.id_is_load  = ($urandom_range(0, 2) == 0);
    bus.id_we       = ($urandom_range(0, 3) != 0);
    bus.id_ctrl     = CTRL_W'($urandom);
    bus.id_imm      = $urandom;
    bus.id_pc       = $urandom;
    bus.wb_we       = 1'($urandom);
    bus.wb_rd       = 5'($urandom_range(0, 7));
    bus.wb_wd       = $urandom;
    bus.ex_stall    = ($urandom_range(0, 5) == 0);
    bus.flush       = ($urandom_range(0, 7) == 0);
  endtask

  // One clock: combinational checks, edge, model update, register checks, RF write; ends on negedge
  task automatic stepCycle();
    #1;
    checkOutput("rf_a1", 64'(bus.rf_a1), 64'(bus.id_rs1));
    checkOutput("rf_a2", 64'(bus.rf_a2), 64'(bus.id_rs2));
    checkOutput("id_stall", 64'(bus.id_stall), 64'(expectedStall()));
    @(posedge clk);
    modelEdge();
    #1;
    checkRegs();
    if (bus.wb_we && bus.wb_rd != '0) rfMem[bus.wb_rd] = bus.wb_wd;
    @(negedge clk);
  endtask

  task automatic setLoadX7();
    clearInputs();
    bus.id_valid = 1; bus.id_rd = 5'd7; bus.id_is_load = 1; bus.id_we = 1;
    bus.id_rs1 = 5'd2; bus.id_uses_rs1 = 1;
  endtask

  task automatic setAddX8X7X1(input logic usesRs1);
    clearInputs();
    bus.id_valid = 1; bus.id_rd = 5'd8; bus.id_we = 1;
    bus.id_rs1 = 5'd7; bus.id_rs2 = 5'd1;
    bus.id_uses_rs1 = usesRs1; bus.id_uses_rs2 = 1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int i = 0; i < 32; i++) rfMem[i] = $urandom;
    rfMem[0] = '0;

    // Reset held with random inputs toggling
    rst_n = 0;
    applyStimulus();
    #23;
    checkResetState();
    modelReset();
    @(negedge clk);
    clearInputs();
    rst_n = 1;

    // First transaction after reset
    bus.id_valid = 1; bus.id_rs1 = 5'd3; rfMem[3] = 32'h11;
    stepCycle();
    checkOutput("first_valid", 64'(bus.ex_valid), 64'd1);
    checkOutput("first_rs1_val", 64'(bus.ex_rs1_val), 64'h11);

    // Same-cycle writeback bypass, then x0 never bypassed
    clearInputs();
    bus.id_valid = 1; bus.id_rs2 = 5'd5; rfMem[5] = 32'h1234;
    bus.wb_we = 1; bus.wb_rd = 5'd5; bus.wb_wd = 32'hDEAD;
    stepCycle();
    checkOutput("wb_bypass", 64'(bus.ex_rs2_val), 64'hDEAD);
    bus.wb_rd = 5'd0; bus.id_rs2 = 5'd0;
    stepCycle();
    checkOutput("wb_rd0", 64'(bus.ex_rs2_val), 64'd0);

    // Load-use: one bubble, dependent enters on the following edge
    setLoadX7();
    stepCycle();
    setAddX8X7X1(1'b1);
    #1 checkOutput("lu_stall", 64'(bus.id_stall), 64'd1);
    stepCycle();
    checkOutput("lu_bubble", 64'(bus.ex_valid), 64'd0);
    checkOutput("lu_cnt", 64'(bus.bubble_cnt), 64'd1);
    stepCycle();
    checkOutput("lu_enter", 64'(bus.ex_valid), 64'd1);
    checkOutput("lu_enter_rd", 64'(bus.ex_rd), 64'd8);

    // Same pair but rs1 not read: no hazard
    setLoadX7();
    stepCycle();
    setAddX8X7X1(1'b0);
    #1 checkOutput("nolu_stall", 64'(bus.id_stall), 64'd0);
    stepCycle();
    checkOutput("nolu_valid", 64'(bus.ex_valid), 64'd1);

    // EX stall for three edges with a writeback to rs1 landing during the stall
    clearInputs();
    bus.id_valid = 1; bus.id_rs1 = 5'd4; bus.id_uses_rs1 = 1; bus.id_rd = 5'd9;
    bus.id_we = 1; bus.id_imm = 32'h55;
    stepCycle();
    bus.ex_stall = 1;
    bus.wb_we = 1; bus.wb_rd = 5'd4; bus.wb_wd = 32'hBEEF;
    for (int i = 0; i < 3; i++) begin
      #1 checkOutput("stall_id_stall", 64'(bus.id_stall), 64'd1);
      stepCycle();
      checkOutput("stall_hold_imm", 64'(bus.ex_imm), 64'h55);
      bus.wb_we = 0;
    end
    bus.ex_stall = 0;
    stepCycle();
    checkOutput("stall_release_rs1", 64'(bus.ex_rs1_val), 64'hBEEF);

    // Flush together with load-use and EX stall
    setLoadX7();
    stepCycle();
    setAddX8X7X1(1'b1);
    bus.ex_stall = 1; bus.flush = 1;
    #1 checkOutput("flush_id_stall", 64'(bus.id_stall), 64'd0);
    stepCycle();
    checkOutput("flush_valid", 64'(bus.ex_valid), 64'd0);
    checkOutput("flush_cnt", 64'(bus.bubble_cnt), 64'd1);

    // Reset while a load-use stall is active
    setLoadX7();
    stepCycle();
    setAddX8X7X1(1'b1);
    #1 checkOutput("pre_rst_stall", 64'(bus.id_stall), 64'd1);
    rst_n = 0;
    #1;
    checkOutput("mid_rst_stall", 64'(bus.id_stall), 64'd0);
    checkOutput("mid_rst_valid", 64'(bus.ex_valid), 64'd0);
    checkOutput("mid_rst_cnt", 64'(bus.bubble_cnt), 64'd0);
    modelReset();
    @(negedge clk);
    rst_n = 1;
    clearInputs();

    // Saturation: preload the counter near its ceiling, then 32 bubbles
    force dut.bubble_cnt_q = 32'hFFFF_FFF0;
    #1 release dut.bubble_cnt_q;
    mCnt = 32'hFFFF_FFF0;
    for (int i = 0; i < 32; i++) begin
      setLoadX7();
      stepCycle();
      setAddX8X7X1(1'b1);
      stepCycle();
    end
    checkOutput("sat_cnt", 64'(bus.bubble_cnt), 64'hFFFF_FFFF);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      applyStimulus();
      stepCycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
